conv_mac_core: RTL and testbench

CONV_MAC_CORE -- requirements
Module: conv_mac_core

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_chan_sum.sv | 51 +++++
 rtl/conv_mac_core.sv | 122 ++++++++++++
 tb/tb_conv_mac_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution MAC core.
//   - default parameter values for conv_mac_core
//   - clog2: ceiling log2 for deriving widths at elaboration time
//   - sat_relu: clamp a wide signed value into an OW-bit signed range,
//     optionally forcing negatives to zero
package conv_pkg;

  localparam int CH_DEF    = 3;
  localparam int K_DEF     = 5;
  localparam int DW_DEF    = 12;
  localparam int WW_DEF    = 8;
  localparam int BW_DEF    = 16;
  localparam int OW_DEF    = 14;
  localparam int SHIFT_DEF = 6;
  localparam int RELU_DEF  = 0;

  // Smallest r with 2**r >= v (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // The accumulator is carried at 64 bits here so a single function serves
  // every parameterisation; callers narrow the result to OW bits.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int ow,
                                                  input bit relu);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv_chan_sum.sv
// One input channel of the convolution: KK signed multiplies registered
// (pipeline stage 1), then their sum registered (pipeline stage 2).
// Ports:
//   clk, rst   clock, async active-high reset
//   i_en       pipeline advance; both stages load only when high
//   i_smp      KK packed DW-bit signed samples, tap 0 in the LSBs
//   i_wgt      KK packed WW-bit signed weights, same tap order
//   o_sum      AW-bit signed channel sum (stage 2 register)
module conv_chan_sum #(
  parameter int KK = 25,
  parameter int DW = 12,
  parameter int WW = 8,
  parameter int AW = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [KK*DW-1:0]     i_smp,
  input  logic [KK*WW-1:0]     i_wgt,
  output logic signed [AW-1:0] o_sum
);

  localparam int PW = DW + WW;

  logic signed [PW-1:0] r_prod [KK];
  logic signed [AW-1:0] r_sum;
  logic signed [AW-1:0] w_sum;

  // Both operands are signed, so the product is formed at full PW width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KK; i++) r_prod[i] <= '0;
    end else if (i_en) begin
      for (int i = 0; i < KK; i++)
        r_prod[i] <= $signed(i_smp[i*DW +: DW]) * $signed(i_wgt[i*WW +: WW]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++) w_sum = w_sum + AW'(r_prod[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_sum <= '0;
    else if (i_en) r_sum <= w_sum;
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/conv_mac_core.sv
// Streaming CH x K x K convolution MAC with a four-stage pipeline:
//   S1 per-tap products, S2 per-channel sums (both in conv_chan_sum),
//   S3 cross-channel sum plus bias, S4 shift/saturate/ReLU into out_data.
// All stages advance together on en = ~out_valid | out_ready, so a stalled
// output freezes the whole pipe and nothing is dropped or duplicated.
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid/in_ready/in_data  window input, NT packed DW-bit samples
//   wr_en/wr_addr/wr_data      coefficient write (addr NT = bias)
//   wr_err                     one-cycle pulse after a rejected write
//   out_valid/out_ready        result handshake
//   out_data                   OW-bit signed result
module conv_mac_core
  import conv_pkg::*;
#(
  parameter  int CH    = CH_DEF,
  parameter  int K     = K_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int WW    = WW_DEF,
  parameter  int BW    = BW_DEF,
  parameter  int OW    = OW_DEF,
  parameter  int SHIFT = SHIFT_DEF,
  parameter  int RELU  = RELU_DEF,
  localparam int KK    = K * K,
  localparam int NT    = CH * KK,
  localparam int AW    = DW + WW + clog2(NT),
  localparam int AIW   = clog2(NT + 1),
  localparam int CW    = (WW > BW) ? WW : BW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NT*DW-1:0] in_data,
  input  logic             wr_en,
  input  logic [AIW-1:0]   wr_addr,
  input  logic [CW-1:0]    wr_data,
  output logic             wr_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    out_data
);

  localparam int STAGES = 4;

  logic [NT*WW-1:0]     r_wgt;
  logic [BW-1:0]        r_bias;
  logic                 r_wr_err;
  logic [STAGES:1]      r_vld_pipe;
  logic signed [AW-1:0] r_acc;
  logic [OW-1:0]        r_out;

  logic                 w_en;
  logic                 w_wr_ok;
  logic signed [AW-1:0] w_csum [CH];
  logic signed [AW-1:0] w_acc;
  logic signed [AW-1:0] w_shift;

  assign w_en     = ~r_vld_pipe[STAGES] | out_ready;
  assign in_ready = w_en;

  // Coefficients may only change while the pipe is completely idle, so every
  // window in flight sees one consistent set of weights and bias.
  assign w_wr_ok = wr_en && ~|r_vld_pipe && ~in_valid && (wr_addr <= AIW'(NT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wgt    <= '0;
      r_bias   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en & ~w_wr_ok;
      if (w_wr_ok) begin
        if (wr_addr == AIW'(NT)) r_bias <= wr_data[BW-1:0];
        else                     r_wgt[int'(wr_addr)*WW +: WW] <= wr_data[WW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_vld_pipe <= '0;
    else if (w_en) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
  end

  // S1 and S2 live in the per-channel instances.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    conv_chan_sum #(
      .KK(KK), .DW(DW), .WW(WW), .AW(AW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en),
      .i_smp (in_data[c*KK*DW +: KK*DW]),
      .i_wgt (r_wgt[c*KK*WW +: KK*WW]),
      .o_sum (w_csum[c])
    );
  end

  // S3: cross-channel sum with the sign-extended bias.
  always_comb begin
    w_acc = AW'($signed(r_bias));
    for (int c = 0; c < CH; c++) w_acc = w_acc + w_csum[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_acc <= '0;
    else if (w_en) r_acc <= w_acc;
  end

  // S4: floor shift (arithmetic), then clamp to the output range.
  assign w_shift = r_acc >>> SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_out <= '0;
    else if (w_en) r_out <= OW'(sat_relu(64'(w_shift), OW, RELU != 0));
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out_data  = r_out;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_conv_mac_core.sv
module tb_conv_mac_core;
  localparam int CH = 3, K = 5, DW = 12, WW = 8, BW = 16, OW = 14;
  localparam int NT = CH * K * K;
  localparam int AIW = 7;
  localparam int CW = 16;

  typedef struct { int d; int c; bit lat; } exp_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, wr_en = 0, out_ready = 1;
  logic [NT*DW-1:0] in_data = '0;
  logic [AIW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic in_ready0, in_ready1, wr_err0, wr_err1, out_valid0, out_valid1;
  logic signed [OW-1:0] out_data0, out_data1;

  int errs = 0, checks = 0, cyc = 0;
  bit saw_stall = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_core #(.RELU(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0));

  conv_mac_core #(.RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic [NT*DW-1:0] fill(input int v);
    logic [NT*DW-1:0] r;
    for (int i = 0; i < NT; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [NT*DW-1:0] one(input int v);
    logic [NT*DW-1:0] r;
    r = '0;
    r[DW-1:0] = DW'(v);
    return r;
  endfunction

  // All stimulus tasks start and end just after a rising edge.
  task automatic wr(input int a, input int d, input bit exp_err);
    in_valid = 0; wr_en = 1; wr_addr = AIW'(a); wr_data = CW'(d);
    @(posedge clk); #1;
    wr_en = 0;
    check("wr_err0", int'(wr_err0), int'(exp_err));
    check("wr_err1", int'(wr_err1), int'(exp_err));
  endtask

  task automatic send(input logic [NT*DW-1:0] d, input int e, input bit lat);
    int n;
    exp_t x;
    in_valid = 1; in_data = d; n = 0;
    forever begin
      #1;
      if (in_ready0) break;
      @(posedge clk); #1;
      n++;
      if (n > 200) begin check("in_ready_timeout", 0, 1); break; end
    end
    x.d = e; x.c = cyc; x.lat = lat;
    q0.push_back(x);
    x.d = (e < 0) ? 0 : e;
    q1.push_back(x);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  // Monitors: pop and compare on each output handshake; while stalled the
  // output must hold and in_ready must be low.
  bit stall0 = 0;
  int pd0 = 0;
  always @(negedge clk) begin
    exp_t x;
    if (rst) stall0 = 0;
    else begin
      if (stall0) begin
        check("hold_valid0", int'(out_valid0), 1);
        check("hold_data0", int'(out_data0), pd0);
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) check("unexpected0", int'(out_data0), -99999);
        else begin
          x = q0.pop_front();
          check("data0", int'(out_data0), x.d);
          if (x.lat) check("latency0", cyc - x.c, 4);
        end
      end
      stall0 = out_valid0 && !out_ready;
      if (stall0) begin
        pd0 = int'(out_data0);
        saw_stall = 1;
        check("stall_in_ready", int'(in_ready0), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (!rst && out_valid1 && out_ready) begin
      if (q1.size() == 0) check("unexpected1", int'(out_data1), -99999);
      else begin
        x = q1.pop_front();
        check("data1_relu", int'(out_data1), x.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_out_valid", int'(out_valid0), 0);
    check("rst_out_data", int'(out_data0), 0);
    check("rst_in_ready", int'(in_ready0), 1);
    check("rst_wr_err", int'(wr_err0), 0);
    check("rst_out_valid1", int'(out_valid1), 0);

    // Unit weights: 75 taps of 1 -> 75>>6 = 1; -75>>6 floors to -2.
    for (int i = 0; i < NT; i++) wr(i, 1, 0);
    wr(NT, 0, 0);
    send(fill(1), 1, 1);
    send(fill(-1), -2, 1);
    send(fill(1), 1, 1);
    drain();

    // Saturation at both ends.
    for (int i = 0; i < NT; i++) wr(i, 127, 0);
    send(fill(2047), 8191, 1);
    send(fill(-2048), -8192, 1);
    drain();

    // Reset mid-stream with a result at the output.
    send(fill(2047), 8191, 1);
    send(fill(2047), 8191, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", int'(out_valid0), 1);
    rst = 1;
    #1;
    check("midrst_out_valid", int'(out_valid0), 0);
    check("midrst_out_data", int'(out_data0), 0);
    check("midrst_out_valid1", int'(out_valid1), 0);
    q0.delete(); q1.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    check("postrst_in_ready", int'(in_ready0), 1);

    // Weights cleared by reset: only the bias contributes, 640>>6 = 10.
    wr(NT, 640, 0);
    send(fill(2047), 10, 1);
    send(fill(3), 10, 1);
    wr(NT, 0, 1);              // pipe busy -> rejected
    send(fill(7), 10, 1);
    drain();
    wr(100, 5, 1);             // address beyond bias
    wr_en = 1; wr_addr = AIW'(NT); wr_data = '0;
    send(fill(1), 10, 1);      // write alongside an accepted window
    wr_en = 0;
    check("wr_with_window", int'(wr_err0), 1);
    drain();

    // Single nonzero tap, output stalled for three cycles.
    wr(NT, 0, 0);
    wr(0, 64, 0);
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join_none
    for (int v = 1; v <= 5; v++) send(one(v), v, 0);
    drain();
    check("saw_stall", int'(saw_stall), 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
